// File: rtl/obc_challenge_monitor.sv
// obc_challenge_monitor
//   Challenge/response watchdog for an on-board computer (OBC). Each round it
//   issues ROUNDS pseudo-random questions from a 16-bit Fibonacci LFSR and
//   grades the OBC's answers. A round can end in one of three ways:
//     - clean pass: every answer correct;
//     - marginal pass: at least PASS_MIN correct, and one strike is recorded;
//     - fail: fewer than PASS_MIN correct.
//   A failed round, or reaching STRIKE_LIMIT strikes, latches a shutdown that
//   requests a switchover and a reset of OBC 1. Only reset clears it.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   enable        permits new rounds to start
//   q_valid       question offered (ISSUE state)
//   q_data        current question, low Q_WIDTH bits of the LFSR
//   q_ready       OBC accepts the question
//   a_valid       OBC answer strobe
//   a_data        OBC answer
//   busy          round in progress (ISSUE, WAIT, EVAL)
//   round_done    one-cycle pulse in EVAL
//   round_pass    verdict of the last round, held until the next round_done
//   correct_count correct answers in the current or last round
//   strike_count  accumulated marginal passes, saturating at 15
//   override      shutdown indication to the OBC switchover
//   obc_reset     reset request to OBC 1
module obc_challenge_monitor #(
  parameter int unsigned Q_WIDTH      = 4,
  parameter int unsigned ROUNDS       = 10,
  parameter int unsigned PASS_MIN     = 7,
  parameter int unsigned STRIKE_LIMIT = 3,
  parameter int unsigned TIMEOUT      = 255,
  parameter int unsigned INTERVAL     = 1000,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  output logic                             q_valid,
  output logic [Q_WIDTH-1:0]               q_data,
  input  logic                             q_ready,
  input  logic                             a_valid,
  input  logic [Q_WIDTH-1:0]               a_data,
  output logic                             busy,
  output logic                             round_done,
  output logic                             round_pass,
  output logic [$clog2(ROUNDS+1)-1:0]      correct_count,
  output logic [3:0]                       strike_count,
  output logic                             override,
  output logic                             obc_reset
);

  localparam int unsigned CW = $clog2(ROUNDS + 1);
  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam int unsigned IW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;

  localparam logic [15:0]   SEED_EFF    = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [CW-1:0] ROUNDS_C    = CW'(ROUNDS);
  localparam logic [CW-1:0] PASS_C      = CW'(PASS_MIN);
  localparam logic [7:0]    IDX_LAST    = 8'(ROUNDS - 1);
  localparam logic [TW-1:0] TIMER_LAST  = TW'(TIMEOUT - 1);
  localparam logic [IW-1:0] IVL_LAST    = IW'(INTERVAL - 1);
  localparam logic [3:0]    STRIKE_LIM  = 4'(STRIKE_LIMIT);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ISSUE    = 3'd1;
  localparam logic [2:0] S_WAIT     = 3'd2;
  localparam logic [2:0] S_EVAL     = 3'd3;
  localparam logic [2:0] S_VALID    = 3'd4;
  localparam logic [2:0] S_SHUTDOWN = 3'd5;

  logic [2:0]         state;
  logic [15:0]        lfsr;
  logic [Q_WIDTH-1:0] exp_q;
  logic [7:0]         idx;
  logic [TW-1:0]      timer;
  logic [IW-1:0]      ivl_cnt;

  logic               feedback;
  logic [Q_WIDTH-1:0] exp_next;
  logic               ans_hit;
  logic               q_end;
  logic [CW-1:0]      count_after;
  logic [3:0]         strike_inc;

  always_comb begin
    feedback    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    // bit 0 is inverted, every higher bit is the XOR with its lower neighbour
    exp_next    = lfsr[Q_WIDTH-1:0] ^ {lfsr[Q_WIDTH-2:0], 1'b1};
    ans_hit     = (state == S_WAIT) && a_valid && (a_data == exp_q);
    // an answer on the timeout cycle is graded, not treated as a timeout
    q_end       = (state == S_WAIT) && (a_valid || (timer == TIMER_LAST));
    count_after = correct_count + CW'(ans_hit);
    strike_inc  = (strike_count == 4'hF) ? 4'hF : strike_count + 4'd1;
  end

  // The LFSR advances on the handshake, so the expected answer is captured
  // at that moment rather than recomputed from q_data during WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      lfsr          <= SEED_EFF;
      exp_q         <= '0;
      idx           <= '0;
      timer         <= '0;
      ivl_cnt       <= '0;
      correct_count <= '0;
      strike_count  <= '0;
      round_pass    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable) begin
            correct_count <= '0;
            idx           <= '0;
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (q_ready) begin
            lfsr  <= {lfsr[14:0], feedback};
            exp_q <= exp_next;
            timer <= '0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (q_end) begin
            correct_count <= count_after;
            if (idx == IDX_LAST) begin
              round_pass <= (count_after >= PASS_C);
              state      <= S_EVAL;
            end else begin
              idx   <= idx + 8'd1;
              state <= S_ISSUE;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_EVAL: begin
          ivl_cnt <= '0;
          if (correct_count == ROUNDS_C) begin
            state <= S_VALID;
          end else if (correct_count >= PASS_C) begin
            strike_count <= strike_inc;
            state        <= (strike_inc >= STRIKE_LIM) ? S_SHUTDOWN : S_VALID;
          end else begin
            state <= S_SHUTDOWN;
          end
        end
        S_VALID: begin
          if (!enable) begin
            state <= S_IDLE;
          end else if (ivl_cnt == IVL_LAST) begin
            ivl_cnt       <= '0;
            correct_count <= '0;
            idx           <= '0;
            state         <= S_ISSUE;
          end else begin
            ivl_cnt <= ivl_cnt + IW'(1);
          end
        end
        S_SHUTDOWN: begin
          state <= S_SHUTDOWN;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign q_valid    = (state == S_ISSUE);
  assign q_data     = lfsr[Q_WIDTH-1:0];
  assign busy       = (state == S_ISSUE) || (state == S_WAIT) || (state == S_EVAL);
  assign round_done = (state == S_EVAL);
  assign override   = (state == S_SHUTDOWN);
  assign obc_reset  = (state == S_SHUTDOWN);

endmodule

// File: tb/tb_obc_challenge_monitor.sv
// Directed bench for obc_challenge_monitor. The scenario driver keeps a
// timeline of what the monitor must be doing (phase, counts, strikes, verdict)
// and the question list is precomputed from the seed. A negedge process
// compares every output against those expectations on every cycle.
module tb_obc_challenge_monitor;

  localparam int QW   = 4;
  localparam int NR   = 10;
  localparam int PMIN = 7;
  localparam int SLIM = 3;
  localparam int TMO  = 255;
  localparam int IVL  = 1000;

  localparam int PH_IDLE  = 0;
  localparam int PH_ASK   = 1;
  localparam int PH_WAIT  = 2;
  localparam int PH_EVAL  = 3;
  localparam int PH_PAUSE = 4;
  localparam int PH_DEAD  = 5;

  localparam int K_OK  = 0;
  localparam int K_BAD = 1;
  localparam int K_TMO = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          q_ready = 1'b0;
  logic          a_valid = 1'b0;
  logic [QW-1:0] a_data = '0;
  logic          q_valid;
  logic [QW-1:0] q_data;
  logic          busy;
  logic          round_done;
  logic          round_pass;
  logic [3:0]    correct_count;
  logic [3:0]    strike_count;
  logic          override;
  logic          obc_reset;

  obc_challenge_monitor #(
    .Q_WIDTH(QW), .ROUNDS(NR), .PASS_MIN(PMIN), .STRIKE_LIMIT(SLIM),
    .TIMEOUT(TMO), .INTERVAL(IVL), .SEED(16'hACE1)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .q_valid(q_valid), .q_data(q_data), .q_ready(q_ready),
    .a_valid(a_valid), .a_data(a_data),
    .busy(busy), .round_done(round_done), .round_pass(round_pass),
    .correct_count(correct_count), .strike_count(strike_count),
    .override(override), .obc_reset(obc_reset)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nbad = 0;
  bit chk_on = 1'b0;

  logic [15:0] qlist [0:127];
  int          ph;
  int          e_count;
  int          e_strike;
  bit          e_pass;
  int          qpos;
  int          qi;
  logic [3:0]  cur_q;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], ^(l & 16'hB400)};
  endfunction

  function automatic logic [3:0] answer_of(input logic [3:0] q);
    logic [3:0] e;
    e[0] = ~q[0];
    for (int i = 1; i < QW; i++) e[i] = q[i-1] ^ q[i];
    return e;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    nvec++;
    if (act != expv) begin
      nbad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("q_valid",       q_valid,       ph == PH_ASK);
      check("q_data",        q_data,        qlist[qpos][3:0]);
      check("busy",          busy,          ph == PH_ASK || ph == PH_WAIT || ph == PH_EVAL);
      check("round_done",    round_done,    ph == PH_EVAL);
      check("round_pass",    round_pass,    e_pass);
      check("correct_count", correct_count, e_count);
      check("strike_count",  strike_count,  e_strike);
      check("override",      override,      ph == PH_DEAD);
      check("obc_reset",     obc_reset,     ph == PH_DEAD);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_expect();
    ph = PH_IDLE; e_count = 0; e_strike = 0; e_pass = 1'b0; qpos = 0; qi = 0;
  endtask

  // Called just after a rising edge; asserts reset mid-cycle and releases it
  // mid-cycle one clock later.
  task automatic do_reset();
    enable = 1'b0; q_ready = 1'b0; a_valid = 1'b0;
    #2 reset = 1'b0;
    clear_expect();
    #1;
    check("rst_q_valid", q_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_strike", strike_count, 0);
    check("rst_override", override, 0);
    check("rst_q_data", q_data, 4'h1);
    tick();
    #2 reset = 1'b1;
  endtask

  task automatic start_round();
    enable = 1'b1;
    tick();
    ph = PH_ASK; e_count = 0; qi = 0;
  endtask

  // Holds q_ready low for rdelay cycles while strobing an answer that must be
  // ignored, then completes the handshake.
  task automatic handshake(input int rdelay);
    for (int i = 0; i < rdelay; i++) begin
      q_ready = 1'b0;
      a_valid = 1'b1;
      a_data  = answer_of(qlist[qpos][3:0]);
      tick();
    end
    a_valid = 1'b0;
    q_ready = 1'b1;
    tick();
    q_ready = 1'b0;
    cur_q   = qlist[qpos][3:0];
    qpos++;
    ph = PH_WAIT;
  endtask

  // q_ready is held high throughout WAIT; it must not advance the question.
  task automatic answer(input int kind, input int adelay);
    logic [3:0] good;
    good = answer_of(cur_q);
    q_ready = 1'b1;
    if (kind == K_TMO) begin
      repeat (TMO) tick();
    end else begin
      repeat (adelay) tick();
      a_valid = 1'b1;
      a_data  = (kind == K_OK) ? good : (good ^ 4'b0001);
      tick();
      a_valid = 1'b0;
      if (kind == K_OK) e_count++;
    end
    q_ready = 1'b0;
    qi++;
    if (qi == NR) begin
      ph = PH_EVAL;
      e_pass = (e_count >= PMIN);
    end else begin
      ph = PH_ASK;
    end
  endtask

  task automatic run_round(input int n_bad, input int bad_kind);
    for (int i = 0; i < NR; i++) begin
      handshake(i % 2);
      answer((i >= NR - n_bad) ? bad_kind : K_OK, i % 4);
    end
  endtask

  task automatic finish_eval();
    tick();
    if (e_count == NR) begin
      ph = PH_PAUSE;
    end else if (e_count >= PMIN) begin
      if (e_strike < 15) e_strike++;
      ph = (e_strike >= SLIM) ? PH_DEAD : PH_PAUSE;
    end else begin
      ph = PH_DEAD;
    end
  endtask

  task automatic pause_full();
    repeat (IVL) tick();
    ph = PH_ASK; e_count = 0; qi = 0;
  endtask

  initial begin
    qlist[0] = 16'hACE1;
    for (int i = 1; i < 128; i++) qlist[i] = lfsr_step(qlist[i-1]);
    clear_expect();

    #2 reset = 1'b0;
    chk_on = 1'b1;
    #1;
    check("por_q_data", q_data, 4'h1);
    check("por_round_pass", round_pass, 0);
    check("por_obc_reset", obc_reset, 0);
    tick();
    #2 reset = 1'b1;
    repeat (3) tick();

    // Clean round: long q_ready stall, answer on the timeout cycle.
    start_round();
    check("q0_literal", q_data, 4'h1);
    handshake(500);
    check("q1_literal", q_data, 4'h3);
    answer(K_OK, 0);
    handshake(0);
    check("q2_literal", q_data, 4'h7);
    answer(K_OK, TMO - 1);
    for (int i = 2; i < NR; i++) begin
      handshake(i % 2);
      answer(K_OK, i % 3);
    end
    check("clean_done", round_done, 1);
    check("clean_pass", round_pass, 1);
    check("clean_count", correct_count, 10);
    finish_eval();
    check("clean_strike", strike_count, 0);
    pause_full();
    check("clean_next_issue", q_valid, 1);

    // Two marginal rounds, then reset in the middle of a question.
    run_round(2, K_TMO);
    check("marg1_count", correct_count, 8);
    check("marg1_pass", round_pass, 1);
    finish_eval();
    check("marg1_strike", strike_count, 1);
    pause_full();
    run_round(2, K_TMO);
    finish_eval();
    check("marg2_strike", strike_count, 2);
    pause_full();
    handshake(0);
    answer(K_OK, 1);
    handshake(0);
    repeat (5) tick();
    do_reset();
    start_round();
    check("post_reset_q0", q_data, 4'h1);

    // Three marginal rounds reach the strike limit.
    run_round(2, K_TMO);
    finish_eval();
    check("strike_a", strike_count, 1);
    pause_full();
    run_round(2, K_TMO);
    finish_eval();
    check("strike_b", strike_count, 2);
    pause_full();
    run_round(2, K_TMO);
    finish_eval();
    check("strike_c", strike_count, 3);
    check("limit_override", override, 1);
    check("limit_obc_reset", obc_reset, 1);
    for (int i = 0; i < 20; i++) begin
      enable  = i[0];
      q_ready = i[1];
      a_valid = i[2];
      tick();
    end
    q_ready = 1'b0; a_valid = 1'b0;
    check("shutdown_held", override, 1);

    // Six correct answers: immediate shutdown with no strikes.
    do_reset();
    start_round();
    run_round(4, K_BAD);
    check("fail_pass", round_pass, 0);
    check("fail_count", correct_count, 6);
    finish_eval();
    check("fail_override", override, 1);
    check("fail_strike", strike_count, 0);

    // Dropping enable during the interval returns to idle.
    do_reset();
    start_round();
    run_round(0, K_OK);
    finish_eval();
    repeat (10) tick();
    enable = 1'b0;
    tick();
    ph = PH_IDLE;
    check("valid_to_idle_busy", busy, 0);
    repeat (5) tick();
    start_round();
    check("idle_clears_count", correct_count, 0);
    tick();

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
